// File: rtl/bootrom_dtim_loader.sv
// rtl/bootrom_dtim_loader.sv - copies a run of boot ROM words into DTIM and sums them
module bootrom_dtim_loader #(
    parameter int ROM_AW = 11,
    parameter int DW     = 32,
    parameter int RAM_AW = 12,
    parameter int CNT_W  = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ROM_AW-1:0] src_base,
    input  logic [RAM_AW-1:0] dst_base,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     checksum,
    output logic              rom_me,
    output logic              rom_oe,
    output logic [ROM_AW-1:0] rom_address,
    input  logic [DW-1:0]     rom_q,
    output logic              ram_wen,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [DW-1:0]     ram_wdata,
    input  logic              ram_ready
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] src_q;
    logic [RAM_AW-1:0] dst_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  idx_inc;
    logic [DW-1:0]     hold_q;
    logic [DW-1:0]     sum_q;

    assign idx_inc = idx_q + CNT_W'(1);

    // Address outputs are derived from registers only, so they collapse to zero
    // the moment reset asserts and stay stable across RAM back-pressure.
    assign rom_address = src_q + ROM_AW'(idx_q);
    assign ram_waddr   = dst_q + RAM_AW'(idx_q);
    assign ram_wdata   = hold_q;
    assign checksum    = sum_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q <= src_base;
                        dst_q <= dst_base;
                        cnt_q <= word_count;
                        idx_q <= '0;
                        sum_q <= '0;
                    end
                end
                CAPTURE: hold_q <= rom_q;
                WRITE: begin
                    if (ram_ready) begin
                        sum_q <= sum_q + hold_q;
                        idx_q <= idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        rom_me  = 1'b0;
        rom_oe  = 1'b0;
        ram_wen = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (word_count != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                busy    = 1'b1;
                rom_me  = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                busy    = 1'b1;
                rom_oe  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                busy    = 1'b1;
                ram_wen = 1'b1;
                if (ram_ready) begin
                    state_d = (idx_inc == cnt_q) ? DONE : ISSUE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bootrom_dtim_loader.sv
// tb/tb_bootrom_dtim_loader.sv - scoreboard bench for bootrom_dtim_loader
module tb_bootrom_dtim_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] src_base = '0;
    logic [11:0] dst_base = '0;
    logic [11:0] word_count = '0;
    logic        busy, done, rom_me, rom_oe, ram_wen;
    logic [31:0] checksum, rom_q, ram_wdata;
    logic [10:0] rom_address;
    logic [11:0] ram_waddr;
    logic        ram_ready = 1'b1;

    always #5 clock = ~clock;

    bootrom_dtim_loader dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum),
        .rom_me      (rom_me),
        .rom_oe      (rom_oe),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .ram_wen     (ram_wen),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_ready   (ram_ready)
    );

    // Synchronous ROM macro: data appears one cycle after me, driven only under oe
    logic [31:0] rom [0:2047];
    logic [31:0] rom_reg = '0;
    always @(posedge clock) if (rom_me) rom_reg <= rom[rom_address];
    assign rom_q = rom_oe ? rom_reg : 32'hzzzz_zzzz;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          rel;
    } wr_t;

    wr_t         exp_wr[$];
    logic [10:0] exp_rom[$];
    logic [31:0] exp_sum;
    int n_cmp = 0, n_err = 0;
    int ecount = 0, t_edge = 0;
    int done_cnt = 0, done_rel = -1, me_cnt = 0, wen_cnt = 0;
    bit mon_en = 1'b0;
    logic [10:0] ea;
    wr_t         ew;

    always @(posedge clock) ecount <= ecount + 1;

    always @(negedge clock) begin
        if (mon_en) begin
            if (rom_me) begin
                me_cnt++;
                n_cmp++;
                if (exp_rom.size() == 0) begin
                    n_err++;
                    $display("FAIL rom_me_unexpected: got addr %h, required no read", rom_address);
                end else begin
                    ea = exp_rom.pop_front();
                    if (rom_address !== ea) begin
                        n_err++;
                        $display("FAIL rom_address: got %h, required %h", rom_address, ea);
                    end
                end
            end
            if (ram_wen) wen_cnt++;
            if (ram_wen && ram_ready) begin
                n_cmp++;
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL ram_write_unexpected: got addr %h data %h, required none", ram_waddr, ram_wdata);
                end else begin
                    ew = exp_wr.pop_front();
                    if (ram_waddr !== ew.addr || ram_wdata !== ew.data || (ecount - t_edge) != ew.rel) begin
                        n_err++;
                        $display("FAIL ram_write: got addr %h data %h rel %0d, required addr %h data %h rel %0d",
                                 ram_waddr, ram_wdata, ecount - t_edge, ew.addr, ew.data, ew.rel);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_rel = ecount - t_edge;
            end
        end
    end

    // Pushes the expected reads/writes, then pulses start; returns in cycle T+1
    task automatic launch(input logic [10:0] src, input logic [11:0] dst, input logic [11:0] cnt,
                          input int stall_k, input int stall_len);
        exp_sum = '0;
        for (int k = 0; k < int'(cnt); k++) begin
            logic [10:0] ra;
            wr_t w;
            ra = src + 11'(k);
            exp_rom.push_back(ra);
            w.addr = dst + 12'(k);
            w.data = rom[ra];
            w.rel  = 2 + 3 * k + ((stall_k >= 0 && k >= stall_k) ? stall_len : 0);
            exp_wr.push_back(w);
            exp_sum += rom[ra];
        end
        @(posedge clock); #1;
        start = 1'b1; src_base = src; dst_base = dst; word_count = cnt;
        @(posedge clock); #1;
        t_edge = ecount;
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev, output bit ok);
        ok = 1'b0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clock); #1;
            if (done_cnt != prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if ({busy, done, rom_me, rom_oe, ram_wen, rom_address, ram_waddr, ram_wdata, checksum} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy %b done %b me %b oe %b wen %b ra %h wa %h wd %h sum %h, required all 0",
                     busy, done, rom_me, rom_oe, ram_wen, rom_address, ram_waddr, ram_wdata, checksum);
        end
        @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic test_basic;
        int prev;
        bit ok;
        prev = done_cnt;
        launch(11'h000, 12'h100, 12'd4, -1, 0);
        wait_done(prev, ok);
        n_cmp++;
        if (!ok || done_rel != 12 || checksum !== 32'd10) begin
            n_err++;
            $display("FAIL basic_done: got ok %b rel %0d sum %h, required ok 1 rel 12 sum 0000000a", ok, done_rel, checksum);
        end
        repeat (4) @(posedge clock);
        #1;
        n_cmp++;
        if (done_cnt != prev + 1 || busy !== 1'b0 || exp_wr.size() != 0 || exp_rom.size() != 0) begin
            n_err++;
            $display("FAIL basic_after: got dones %0d busy %b pend_wr %0d pend_rd %0d, required 1 0 0 0",
                     done_cnt - prev, busy, exp_wr.size(), exp_rom.size());
        end
    endtask

    task automatic test_wrap;
        int prev;
        bit ok;
        rom[11'h7FE] = 32'hA; rom[11'h7FF] = 32'hB; rom[11'h000] = 32'hC;
        prev = done_cnt;
        launch(11'h7FE, 12'hFFF, 12'd3, -1, 0);
        wait_done(prev, ok);
        n_cmp++;
        if (!ok || done_rel != 9 || checksum !== 32'h21 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL wrap: got ok %b rel %0d sum %h pend %0d, required ok 1 rel 9 sum 00000021 pend 0",
                     ok, done_rel, checksum, exp_wr.size());
        end
        rom[11'h000] = 32'h1;
    endtask

    task automatic test_backpressure;
        int prev;
        bit ok;
        prev = done_cnt;
        launch(11'h000, 12'h200, 12'd4, 1, 5);
        repeat (5) @(posedge clock);
        #1;
        ram_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            n_cmp++;
            if ({ram_wen, ram_waddr, ram_wdata, rom_me} !== {1'b1, 12'h201, 32'd2, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got wen %b wa %h wd %h me %b, required 1 201 00000002 0",
                         j, ram_wen, ram_waddr, ram_wdata, rom_me);
            end
            @(posedge clock); #1;
        end
        ram_ready = 1'b1;
        wait_done(prev, ok);
        n_cmp++;
        if (!ok || done_rel != 17 || checksum !== 32'd10) begin
            n_err++;
            $display("FAIL stall_done: got ok %b rel %0d sum %h, required ok 1 rel 17 sum 0000000a", ok, done_rel, checksum);
        end
    endtask

    task automatic test_zero_count;
        int prev, me0, wen0;
        bit ok;
        prev = done_cnt; me0 = me_cnt; wen0 = wen_cnt;
        launch(11'h055, 12'h033, 12'd0, -1, 0);
        wait_done(prev, ok);
        n_cmp++;
        if (!ok || done_rel != 0 || checksum !== 32'd0) begin
            n_err++;
            $display("FAIL zero_done: got ok %b rel %0d sum %h, required ok 1 rel 0 sum 00000000", ok, done_rel, checksum);
        end
        repeat (5) @(posedge clock);
        #1;
        n_cmp++;
        if (me_cnt != me0 || wen_cnt != wen0 || done_cnt != prev + 1) begin
            n_err++;
            $display("FAIL zero_activity: got me %0d wen %0d dones %0d, required 0 0 1",
                     me_cnt - me0, wen_cnt - wen0, done_cnt - prev);
        end
    endtask

    task automatic test_ignored_start;
        int prev;
        prev = done_cnt;
        launch(11'h020, 12'h040, 12'd4, -1, 0);
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1; src_base = 11'h300; dst_base = 12'h700; word_count = 12'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        n_cmp++;
        if (done_cnt != prev + 1 || done_rel != 12 || checksum !== exp_sum || busy !== 1'b0 ||
            exp_wr.size() != 0 || exp_rom.size() != 0) begin
            n_err++;
            $display("FAIL ignored_start: got dones %0d rel %0d sum %h busy %b pend %0d, required 1 12 %h 0 0",
                     done_cnt - prev, done_rel, checksum, busy, exp_wr.size(), exp_sum);
        end
    endtask

    task automatic test_overflow;
        int prev;
        bit ok;
        rom[11'h010] = 32'hFFFF_FFFF; rom[11'h011] = 32'h0000_0002;
        prev = done_cnt;
        launch(11'h010, 12'h000, 12'd2, -1, 0);
        wait_done(prev, ok);
        n_cmp++;
        if (!ok || done_rel != 6 || checksum !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL overflow: got ok %b rel %0d sum %h, required ok 1 rel 6 sum 00000001", ok, done_rel, checksum);
        end
    endtask

    task automatic test_reset_mid_copy;
        int prev;
        bit ok;
        launch(11'h000, 12'h080, 12'd10, -1, 0);
        repeat (8) @(posedge clock);
        #1;
        n_cmp++;
        if (ram_wen !== 1'b1 || ram_waddr !== 12'h082) begin
            n_err++;
            $display("FAIL mid_write_state: got wen %b wa %h, required 1 082", ram_wen, ram_waddr);
        end
        mon_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, rom_me, rom_oe, ram_wen, rom_address, ram_waddr, ram_wdata, checksum} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got busy %b wen %b wa %h wd %h sum %h, required all 0",
                     busy, ram_wen, ram_waddr, ram_wdata, checksum);
        end
        exp_wr.delete();
        exp_rom.delete();
        @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        prev = done_cnt;
        launch(11'h000, 12'h080, 12'd10, -1, 0);
        wait_done(prev, ok);
        n_cmp++;
        if (!ok || done_rel != 30 || checksum !== 32'd55 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL restart_copy: got ok %b rel %0d sum %h pend %0d, required ok 1 rel 30 sum 00000037 pend 0",
                     ok, done_rel, checksum, exp_wr.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 32'(i + 1);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_ignored_start();
        test_overflow();
        test_reset_mid_copy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
